period_meter: RTL and testbench
===============================

# period_meter

Measures the period of a slow, asynchronous square wave, such as a divided 1 Hz blink clock or an external pulse source, in CLK100MHZ cycles. It is the receiving end of our clock-divider outputs: it synchronises the input, detects rising edges, and counts system clocks between them. It delivers each measurement over a valid/ready handshake and flags a timeout when the input stops toggling.

## Interface
- CNT_W, 32: width of the period counter and the PERIOD / HIGH_TIME outputs.
- TIMEOUT_CYC, 200_000_000: cycles without a rising edge before the meter declares timeout (2 s at 100 MHz). Must satisfy 2 ≤ TIMEOUT_CYC ≤ 2^CNT_W−1.
- SYNC_STAGES, 2: synchroniser depth on SIG_IN, at least 2.

Ports:
- CLK100MHZ in 1: system clock; all logic on its rising edge.
- RESETN in 1: asynchronous, active-low reset.
- SIG_IN in 1: measured signal, asynchronous to CLK100MHZ.
- PERIOD out CNT_W: last captured period, in cycles.
- HIGH_TIME out CNT_W: high cycles within the captured period (see Configuration).
- PERIOD_VALID out 1: PERIOD / HIGH_TIME hold an unaccepted result.
- PERIOD_READY in 1: consumer accepts the result when high together with PERIOD_VALID.
- OVERRUN out 1: the current result overwrote an unaccepted one.
- TIMEOUT out 1: no rising edge for TIMEOUT_CYC cycles; the meter is re-arming.

## Operation
- Input path:
  - SIG_IN passes through SYNC_STAGES flops, then a one-flop delay.
  - edge = sync & ~sync_d.
  - Only rising edges matter.
- FSM states: IDLE (reset state), MEASURE.
- IDLE:
  - cnt held at 0.
  - On edge: go to MEASURE, cnt←0, TIMEOUT←0. The first edge only arms the meter; nothing is captured.
- MEASURE:
  - No edge: cnt←cnt+1.
  - On edge: PERIOD←cnt+1, HIGH_TIME←hcnt (+1 if sync is high this cycle), PERIOD_VALID←1, cnt←0, stay in MEASURE.
  - With no edge and cnt==TIMEOUT_CYC−1: go to IDLE, TIMEOUT←1, cnt←0. PERIOD, PERIOD_VALID and OVERRUN are unchanged.
  - If edge and timeout condition occur in the same cycle, the edge wins: capture, no timeout.
- Handshake:
  - Accept = PERIOD_VALID & PERIOD_READY.
  - Accept with no capture: PERIOD_VALID←0, OVERRUN←0.
  - Capture while PERIOD_VALID=0, or in the same cycle as accept: load the new result, PERIOD_VALID←1, OVERRUN←0.
  - Capture while PERIOD_VALID=1 and no accept: overwrite with the newest result, OVERRUN←1, PERIOD_VALID stays 1.
- Arithmetic:
  - cnt is CNT_W bits and never wraps, because timeout fires first.
  - PERIOD range is 2..TIMEOUT_CYC. Input periods under 2 cycles, or high/low phases under 1 cycle, are outside spec and may be missed.
- Reset mid-measurement: all state is cleared immediately and the meter returns to IDLE. The next edge only re-arms it.

## Timing
- Reset values: PERIOD=0, HIGH_TIME=0, PERIOD_VALID=0, OVERRUN=0, TIMEOUT=0, state=IDLE, cnt=0.
- Latency: if clock edge k is the first to sample SIG_IN=1, PERIOD_VALID (with its data) is visible after edge k+SYNC_STAGES.
- Definition: rising edges of SIG_IN exactly N cycles apart give PERIOD=N.
- All outputs are registered; no combinational path from PERIOD_READY to any output.
- PERIOD_VALID falls on the edge after accept, unless a capture happens in the same cycle.
- TIMEOUT rises TIMEOUT_CYC cycles after the last edge (counting from the edge cycle). It stays high until the next detected edge.

## Configuration
- PERIOD_DUTY_EN defined:
  - hcnt counts, within the measurement window, the cycles in which the synchronised level is 1.
  - The window runs from the opening edge cycle up to, but excluding, the closing edge.
  - hcnt clears with cnt; HIGH_TIME is captured alongside PERIOD.
- PERIOD_DUTY_EN undefined: no hcnt logic; HIGH_TIME is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then SIG_IN period 1000 cycles, 50% duty, PERIOD_READY=1. Required: the first edge gives no result. Each following result is PERIOD=1000; HIGH_TIME=500 with PERIOD_DUTY_EN, 0 without.
- PERIOD_READY=0 across three periods of 400. Required: PERIOD_VALID stays 1, PERIOD=400, OVERRUN=1 after the second capture. Raise READY: VALID and OVERRUN fall on the next edge.
- TIMEOUT_CYC=5000, SIG_IN stops after one measured period. Required: TIMEOUT=1 exactly 5000 cycles after the last edge, PERIOD retained. Restart the input: TIMEOUT clears on the first edge, and the next result arrives one period later.
- Input period exactly equal to TIMEOUT_CYC (=5000). Required: edge beats timeout, PERIOD=5000, TIMEOUT stays 0.
- RESETN pulsed low mid-period. Required: all outputs 0 asynchronously. After release, the first edge only re-arms; the first PERIOD is correct.
- Accept and capture in the same cycle, period 2 cycles. Required: PERIOD=2, VALID held at 1, OVERRUN=0.

Source files
------------

// File: rtl/period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : period_meter                                                 |
// | Description : Measures the period of a slow asynchronous square wave in    |
// |               CLK100MHZ cycles, between successive rising edges. Each      |
// |               result is offered on a valid/ready handshake. A timeout flag |
// |               is raised when the input stops toggling.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   CNT_W        width of the period counter and PERIOD / HIGH_TIME          |
// |   TIMEOUT_CYC  cycles without a rising edge before TIMEOUT (2..2^CNT_W-1)  |
// |   SYNC_STAGES  synchroniser depth on SIG_IN (>= 2)                         |
// | Ports                                                                      |
// |   CLK100MHZ    in   system clock, rising edge                              |
// |   RESETN       in   asynchronous active-low reset                          |
// |   SIG_IN       in   measured signal, asynchronous                          |
// |   PERIOD       out  last captured period, in cycles                        |
// |   HIGH_TIME    out  high cycles within the captured period                 |
// |   PERIOD_VALID out  PERIOD / HIGH_TIME hold an unaccepted result           |
// |   PERIOD_READY in   consumer accepts when high together with PERIOD_VALID  |
// |   OVERRUN      out  current result overwrote an unaccepted one             |
// |   TIMEOUT      out  no rising edge for TIMEOUT_CYC cycles, re-arming       |
// | Build option                                                               |
// |   PERIOD_DUTY_EN  defined: HIGH_TIME measured; undefined: HIGH_TIME = 0    |
// +----------------------------------------------------------------------------+

module period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 200_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK100MHZ,
  input  logic             RESETN,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             PERIOD_VALID,
  input  logic             PERIOD_READY,
  output logic             OVERRUN,
  output logic             TIMEOUT
);

  localparam logic [CNT_W-1:0] c_TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [0:0]       c_ST_IDLE    = 1'b0;
  localparam logic [0:0]       c_ST_MEASURE = 1'b1;

  // --------------------------------------------------------------------------
  // Input synchroniser and rising-edge detector
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_dly_q;
  logic                   w_sync;
  logic                   w_rise;

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
      level_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];
  assign w_rise = w_sync & ~level_dly_q;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_cnt_at_to;
  logic             w_arm;
  logic             w_capture;
  logic             w_timeout;
  logic             w_count;

  assign w_cnt_at_to = (cnt_q == c_TO_LAST);

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:    if (w_rise) state_d = c_ST_MEASURE;
      c_ST_MEASURE: if (!w_rise && w_cnt_at_to) state_d = c_ST_IDLE;
      default:      state_d = c_ST_IDLE;
    endcase
  end

  // A rising edge always wins over the timeout in the same cycle.
  always_comb begin
    w_arm     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_count   = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        w_arm = w_rise;
      end
      c_ST_MEASURE: begin
        w_capture = w_rise;
        w_timeout = !w_rise && w_cnt_at_to;
        w_count   = !w_rise && !w_cnt_at_to;
      end
      default: begin
        w_arm = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and handshake
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             timeout_q, timeout_d;
  logic             w_accept;

  assign w_accept = valid_q & PERIOD_READY;

  always_comb begin
    // cnt stays at 0 in IDLE and restarts from 0 on every edge or timeout.
    cnt_d     = w_count ? cnt_q + 1'b1 : '0;
    period_d  = period_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    timeout_d = timeout_q;

    if (w_capture) begin
      period_d = cnt_q + 1'b1;
      valid_d  = 1'b1;
      // Overrun only if the previous result is dropped without being taken.
      ovr_d    = valid_q & ~w_accept;
    end else if (w_accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (w_timeout) begin
      timeout_d = 1'b1;
    end else if (w_arm) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      timeout_q <= timeout_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = valid_q;
  assign OVERRUN      = ovr_q;
  assign TIMEOUT      = timeout_q;

  // --------------------------------------------------------------------------
  // Optional high-time measurement
  // --------------------------------------------------------------------------
`ifdef PERIOD_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  // hcnt skips the opening edge cycle but includes the closing one; both are
  // high by construction, so the total equals the high cycles in the window.
  always_comb begin
    hcnt_d = w_count ? hcnt_q + CNT_W'(w_sync) : '0;
    high_d = w_capture ? hcnt_q + CNT_W'(w_sync) : high_q;
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign HIGH_TIME = high_q;
`else
  assign HIGH_TIME = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_period_meter                                              |
// | Description : Self-checking bench for period_meter. A behavioural model    |
// |               works on the sampled SIG_IN history (rise-to-rise distances, |
// |               high-sample counts) and is compared with the DUT on every    |
// |               falling clock edge; directed literal checks pin the model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_period_meter;

  localparam int CW = 32;
  localparam int TC = 5000;
  localparam int S  = 2;
  // READY pattern that lines accept up with capture on a 2-cycle input.
  localparam bit c_RDY_ON_HI = (S % 2) == 0;

  logic          CLK100MHZ;
  logic          RESETN;
  logic          SIG_IN;
  logic          PERIOD_READY;
  logic [CW-1:0] PERIOD;
  logic [CW-1:0] HIGH_TIME;
  logic          PERIOD_VALID;
  logic          OVERRUN;
  logic          TIMEOUT;

  period_meter #(
    .CNT_W      (CW),
    .TIMEOUT_CYC(TC),
    .SYNC_STAGES(S)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .RESETN      (RESETN),
    .SIG_IN      (SIG_IN),
    .PERIOD      (PERIOD),
    .HIGH_TIME   (HIGH_TIME),
    .PERIOD_VALID(PERIOD_VALID),
    .PERIOD_READY(PERIOD_READY),
    .OVERRUN     (OVERRUN),
    .TIMEOUT     (TIMEOUT)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: index n counts sampling clock edges since reset.
  // A rise sampled at index k is seen by the meter at edge k+S.
  // --------------------------------------------------------------------------
  bit            samp [0:99999];
  int            m_n;
  bit            m_armed;
  int            m_t_last;
  int            m_k_open;
  logic [CW-1:0] exp_period;
  logic [CW-1:0] exp_high;
  logic          exp_valid;
  logic          exp_ovr;
  logic          exp_to;

  initial begin : model
    int t;
    int k;
    int h;
    bit det;
    bit acc;
    forever begin
      @(posedge CLK100MHZ or negedge RESETN);
      if (!RESETN) begin
        m_n        = 0;
        m_armed    = 1'b0;
        m_t_last   = 0;
        m_k_open   = 0;
        exp_period = '0;
        exp_high   = '0;
        exp_valid  = 1'b0;
        exp_ovr    = 1'b0;
        exp_to     = 1'b0;
      end else begin
        t       = m_n;
        samp[t] = SIG_IN;
        m_n     = m_n + 1;
        det = (t >= S) && samp[t-S] && (((t - S) == 0) || !samp[t-S-1]);
        acc = exp_valid && PERIOD_READY;
        if (det && m_armed) begin
          k = t - S;
          h = 0;
          for (int i = m_k_open; i < k; i++) h += int'(samp[i]);
          exp_ovr    = exp_valid && !acc;
          exp_valid  = 1'b1;
          exp_period = CW'(k - m_k_open);
`ifdef PERIOD_DUTY_EN
          exp_high   = CW'(h);
`else
          exp_high   = '0;
`endif
          m_k_open   = k;
          m_t_last   = t;
        end else begin
          if (acc) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
          end
          if (det) begin
            m_armed  = 1'b1;
            exp_to   = 1'b0;
            m_k_open = t - S;
            m_t_last = t;
          end else if (m_armed && (t - m_t_last) == TC) begin
            m_armed = 1'b0;
            exp_to  = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge CLK100MHZ);
      if (chk_en) begin
        check("period",    PERIOD,       exp_period);
        check("high_time", HIGH_TIME,    exp_high);
        check("valid",     PERIOD_VALID, exp_valid);
        check("overrun",   OVERRUN,      exp_ovr);
        check("timeout",   TIMEOUT,      exp_to);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus (all inputs change on the falling edge)
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic drive_period(input int per, input int hi);
    SIG_IN = 1'b1;
    cyc(hi);
    SIG_IN = 1'b0;
    cyc(per - hi);
  endtask

  task automatic rand_period(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      SIG_IN       = (i < hi);
      PERIOD_READY = 1'($urandom_range(0, 1));
      cyc(1);
    end
  endtask

  initial begin : stim
    int per;
    int hi;
    RESETN       = 1'b0;
    SIG_IN       = 1'b0;
    PERIOD_READY = 1'b1;
    cyc(4);
    check("reset_period", PERIOD,       '0);
    check("reset_valid",  PERIOD_VALID, '0);
    check("reset_to",     TIMEOUT,      '0);
    RESETN = 1'b1;
    chk_en = 1'b1;
    cyc(3);

    // 1000-cycle, 50% duty input, consumer always ready.
    drive_period(1000, 500);
    check("arm_no_result_period", PERIOD,       '0);
    check("arm_no_result_valid",  PERIOD_VALID, '0);
    repeat (4) drive_period(1000, 500);
    check("p1000_period", PERIOD, 32'd1000);
`ifdef PERIOD_DUTY_EN
    check("p1000_high", HIGH_TIME, 32'd500);
`else
    check("p1000_high", HIGH_TIME, 32'd0);
`endif

    // Consumer stalled across three 400-cycle periods.
    PERIOD_READY = 1'b0;
    repeat (3) drive_period(400, 200);
    SIG_IN = 1'b1;
    cyc(S + 1);
    check("stall_valid",   PERIOD_VALID, 32'd1);
    check("stall_period",  PERIOD,       32'd400);
    check("stall_overrun", OVERRUN,      32'd1);
    PERIOD_READY = 1'b1;
    cyc(1);
    check("drain_valid",   PERIOD_VALID, 32'd0);
    check("drain_overrun", OVERRUN,      32'd0);
    SIG_IN = 1'b0;
    cyc(50);

    // One measured 700-cycle period, then the input stops.
    drive_period(700, 350);
    SIG_IN = 1'b1;
    cyc(100);
    SIG_IN = 1'b0;
    cyc(S + 4900);
    check("to_not_yet", TIMEOUT, 32'd0);
    cyc(1);
    check("to_fired",    TIMEOUT, 32'd1);
    check("to_retained", PERIOD,  32'd700);

    // Restart: first edge clears TIMEOUT, result one period later.
    SIG_IN = 1'b1;
    cyc(S + 1);
    check("restart_to_clear", TIMEOUT, 32'd0);
    cyc(300 - S - 1);
    SIG_IN = 1'b0;
    cyc(300);
    SIG_IN = 1'b1;
    cyc(S + 1);
    check("restart_period", PERIOD, 32'd600);

    // Period equal to TIMEOUT_CYC: the edge wins.
    cyc(2500 - S - 1);
    SIG_IN = 1'b0;
    cyc(2500);
    SIG_IN = 1'b1;
    cyc(S + 1);
    check("edge_wins_period", PERIOD,  32'd5000);
    check("edge_wins_to",     TIMEOUT, 32'd0);

    // Asynchronous reset mid-period.
    cyc(100);
    SIG_IN = 1'b0;
    cyc(200);
    #2;
    RESETN = 1'b0;
    #1;
    check("async_rst_period", PERIOD,       '0);
    check("async_rst_high",   HIGH_TIME,    '0);
    check("async_rst_valid",  PERIOD_VALID, '0);
    check("async_rst_ovr",    OVERRUN,      '0);
    check("async_rst_to",     TIMEOUT,      '0);
    cyc(3);
    RESETN = 1'b1;
    cyc(20);
    drive_period(800, 400);
    check("rearm_period", PERIOD,       '0);
    check("rearm_valid",  PERIOD_VALID, '0);
    drive_period(800, 400);
    SIG_IN = 1'b1;
    cyc(S + 1);
    check("post_rst_period", PERIOD, 32'd800);
    SIG_IN = 1'b0;
    cyc(5);

    // 2-cycle input with accept and capture on the same edge.
    for (int i = 0; i < 10; i++) begin
      SIG_IN       = 1'b1;
      PERIOD_READY = c_RDY_ON_HI;
      cyc(1);
      SIG_IN       = 1'b0;
      PERIOD_READY = !c_RDY_ON_HI;
      cyc(1);
    end
    check("p2_period",  PERIOD,       32'd2);
    check("p2_valid",   PERIOD_VALID, 32'd1);
    check("p2_overrun", OVERRUN,      32'd0);

    // Randomized periods, duty and consumer backpressure.
    for (int i = 0; i < 60; i++) begin
      per = int'($urandom_range(2, 300));
      hi  = int'($urandom_range(1, per - 1));
      rand_period(per, hi);
    end
    rand_period(TC + 150, 40);
    for (int i = 0; i < 20; i++) begin
      per = int'($urandom_range(2, 300));
      hi  = int'($urandom_range(1, per - 1));
      rand_period(per, hi);
    end
    SIG_IN = 1'b0;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
